// File: rtl/vect_pkg.sv
// -----------------------------------------------------------------------------
// vect_pkg
// Shared definitions for the vect_unit compute element and its issue
// controller.
//   VECT_DATA_W / VECT_CTRL_W / VECT_TAG_W : default widths
//   ALU_*                                  : aluCTRL operation codes
// Ports: none (package).
// -----------------------------------------------------------------------------
package vect_pkg;

    localparam int VECT_DATA_W = 32;
    localparam int VECT_CTRL_W = 4;
    localparam int VECT_TAG_W  = 4;

    // aluCTRL codes understood by vect_unit; any other code yields zero.
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR  = 3;
    localparam int ALU_XOR = 4;
    localparam int ALU_SLT = 5;
    localparam int ALU_SLL = 6;
    localparam int ALU_SRA = 7;

endpackage

// File: rtl/vect_rsp_fifo.sv
// -----------------------------------------------------------------------------
// vect_rsp_fifo
// Synchronous result FIFO with a registered head. The head register is the
// only thing driving rdata, so readers see no combinational path from the
// write side, and rdata keeps its last value while the FIFO is empty.
// Ports:
//   clk, rst_n  in        clock, asynchronous active-low reset
//   flush       in   1    clear pointers and count (head data retained)
//   push        in   1    write wdata
//   wdata       in   W    entry to write
//   pop         in   1    consume head (ignored when empty)
//   rvalid      out  1    FIFO non-empty
//   rdata       out  W    head entry
//   count       out  CW   number of stored entries
// -----------------------------------------------------------------------------
module vect_rsp_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [WIDTH-1:0] head;
    logic             do_push;
    logic             do_pop;

    assign do_pop     = pop && (count != '0) && !flush;
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_push    = push && !flush && ((count != FULL) || do_pop);
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            // Next head: the following stored entry, or the incoming one when
            // the FIFO is (or becomes) otherwise empty.
            if (do_pop) begin
                if (count > ONE) begin
                    head <= mem[rd_ptr_nxt];
                end else if (do_push) begin
                    head <= wdata;
                end
            end else if ((count == '0) && do_push) begin
                head <= wdata;
            end
        end
    end

    assign rvalid = (count != '0);
    assign rdata  = head;

endmodule

// File: rtl/vect_unit.sv
// -----------------------------------------------------------------------------
// vect_unit
// Purely combinational ALU used as the compute element behind vect_issue_ctrl.
// Ports:
//   a, b      in   DATA_W  operands
//   alu_ctrl  in   CTRL_W  operation code (vect_pkg::ALU_*)
//   result    out  DATA_W  operation result
//   flags     out  2       {carry/borrow, zero}
// -----------------------------------------------------------------------------
module vect_unit
    import vect_pkg::*;
#(
    parameter int DATA_W = VECT_DATA_W,
    parameter int CTRL_W = VECT_CTRL_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        flags
);

    localparam int SH_W = $clog2(DATA_W);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [DATA_W:0]   wide;
    logic                     carry;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        wide   = '0;
        carry  = 1'b0;
        case (alu_ctrl)
            CTRL_W'(ALU_ADD): begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            CTRL_W'(ALU_SUB): begin
                // Top bit of the widened difference is the unsigned borrow.
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            CTRL_W'(ALU_AND): result = a & b;
            CTRL_W'(ALU_OR):  result = a | b;
            CTRL_W'(ALU_XOR): result = a ^ b;
            CTRL_W'(ALU_SLT): result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            CTRL_W'(ALU_SLL): result = a << b[SH_W-1:0];
            CTRL_W'(ALU_SRA): result = a_s >>> b[SH_W-1:0];
            default:          result = '0;
        endcase
    end

    assign flags = {carry, (result == '0)};

endmodule

// File: rtl/vect_issue_ctrl.sv
// -----------------------------------------------------------------------------
// vect_issue_ctrl
// Request/response front-end for vect_unit. A request is captured into a
// one-deep stage register, vect_unit evaluates from that register, and the
// result is written into a small result FIFO whose head is returned with the
// request tag. Requests are admitted on a credit basis so the FIFO can never
// overflow.
// Ports:
//   clk, rst_n            in   clock, asynchronous active-low reset
//   flush                 in   synchronous clear of stage, FIFO and counter
//   req_valid/req_ready   in/out request handshake
//   req_a, req_b          in   operands
//   req_ctrl              in   aluCTRL code
//   req_tag               in   opaque tag
//   rsp_valid/rsp_ready   out/in response handshake
//   rsp_data, rsp_flags   out  vect_unit result and flags of head entry
//   rsp_tag               out  tag of head entry
//   busy                  out  stage occupied or FIFO non-empty
//   issued_cnt            out  accepted requests since reset/flush (wraps)
// -----------------------------------------------------------------------------
module vect_issue_ctrl
    import vect_pkg::*;
#(
    parameter int DATA_W     = VECT_DATA_W,
    parameter int CTRL_W     = VECT_CTRL_W,
    parameter int TAG_W      = VECT_TAG_W,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [CTRL_W-1:0] req_ctrl,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_flags,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic [CNT_W-1:0]  issued_cnt
);

    localparam int           ENT_W   = DATA_W + 2 + TAG_W;
    localparam int           CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]  DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    logic              ready_en;
    logic              vld_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] alu_result;
    logic [1:0]        alu_flags;
    logic [CW-1:0]     fifo_count;
    logic [ENT_W-1:0]  fifo_rdata;
    logic [CW:0]       occupancy;
    logic              pop;
    logic              accept;

    assign pop    = rsp_valid && rsp_ready;
    // Ops in flight after this edge if nothing new were accepted.
    assign occupancy = ({{CW{1'b0}}, vld_p1} + {1'b0, fifo_count}) - {{CW{1'b0}}, pop};
    // ready_en keeps req_ready low while in reset and releases it on the
    // first clock edge afterwards.
    assign req_ready = ready_en && !flush && (occupancy < DEPTH_V);
    assign accept    = req_valid && req_ready;

    // ---- stage p0 -> p1: request capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            vld_p1     <= 1'b0;
            issued_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                vld_p1     <= 1'b0;
                issued_cnt <= '0;
            end else begin
                // The stage always drains into the FIFO, so it holds only the
                // op accepted on this edge.
                vld_p1 <= accept;
                if (accept) begin
                    issued_cnt <= issued_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1    <= req_a;
            b_p1    <= req_b;
            ctrl_p1 <= req_ctrl;
            tag_p1  <= req_tag;
        end
    end

    vect_unit #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_unit (
        .a        (a_p1),
        .b        (b_p1),
        .alu_ctrl (ctrl_p1),
        .result   (alu_result),
        .flags    (alu_flags)
    );

    // ---- stage p1 -> p2: result FIFO ----
    vect_rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .push   (vld_p1),
        .wdata  ({alu_result, alu_flags, tag_p1}),
        .pop    (pop),
        .rvalid (rsp_valid),
        .rdata  (fifo_rdata),
        .count  (fifo_count)
    );

    assign rsp_data  = fifo_rdata[ENT_W-1 -: DATA_W];
    assign rsp_flags = fifo_rdata[TAG_W +: 2];
    assign rsp_tag   = fifo_rdata[TAG_W-1:0];
    assign busy      = vld_p1 || (fifo_count != '0);

endmodule

// File: tb/tb_vect_issue_ctrl.sv
module tb_vect_issue_ctrl;
    import vect_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  flags;
        logic [3:0]  tag;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] data;
        logic [1:0]  flags;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ctrl;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic [15:0] issued_cnt;

    logic        n_req_ready;
    logic        n_rsp_valid;
    logic [31:0] n_rsp_data;
    logic [1:0]  n_rsp_flags;
    logic [3:0]  n_rsp_tag;
    logic        n_busy;
    logic [3:0]  n_issued;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   acc   = 0;
    int   cyc   = 0;

    vect_issue_ctrl #(.DATA_W(32), .CTRL_W(4), .TAG_W(4), .FIFO_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy), .issued_cnt(issued_cnt)
    );

    // Narrow-counter twin driven by the same stimulus.
    vect_issue_ctrl #(.DATA_W(32), .CTRL_W(4), .TAG_W(4), .FIFO_DEPTH(2), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(n_req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
        .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(n_rsp_data), .rsp_flags(n_rsp_flags), .rsp_tag(n_rsp_tag),
        .busy(n_busy), .issued_cnt(n_issued)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // Reference ALU, written from the operation definitions.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] c, input logic [3:0] t);
        exp_t        e;
        logic [32:0] s;
        logic [31:0] r;
        logic        cy;
        r  = 32'd0;
        cy = 1'b0;
        case (int'(c))
            ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32]; end
            ALU_SUB: begin r = a - b; cy = (a < b); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: r = a << b[4:0];
            ALU_SRA: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'd0;
        endcase
        e.data  = r;
        e.flags = {cy, (r == 32'd0)};
        e.tag   = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Present one request, wait (bounded) for acceptance, record the expected response.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                        input logic [3:0] t, input logic [31:0] ed, input logic [1:0] ef);
        int   waited;
        exp_t e;
        waited    = 0;
        req_a     = a;
        req_b     = b;
        req_ctrl  = c;
        req_tag   = t;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waited);
            req_valid = 1'b0;
            return;
        end
        e.data  = ed;
        e.flags = ef;
        e.tag   = t;
        sb.push_back(e);
        acc++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [3:0] t);
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        exp_t        e;
        a = $urandom;
        b = $urandom;
        c = 4'($urandom_range(0, 8));
        e = model(a, b, c, t);
        send(a, b, c, t, e.data, e.flags);
    endtask

    task automatic drain();
        int w;
        w = 0;
        do begin
            @(posedge clk);
            w++;
        end while (sb.size() != 0 && w < 60);
        #1;
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: a response leaves at the next edge when valid&&ready.
    always @(negedge clk) begin
        if (rst_n && !flush && rsp_valid && rsp_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got tag %h data %h, required no response", rsp_tag, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({rsp_data, rsp_flags, rsp_tag} !== e) begin
                    bad++;
                    $display("FAIL rsp: got data %h flags %b tag %h, required data %h flags %b tag %h",
                             rsp_data, rsp_flags, rsp_tag, e.data, e.flags, e.tag);
                end
            end
        end
    end

    vec_t tbl[11];
    int   c0;

    initial begin
        tbl[0]  = '{32'h5,        32'h3,        4'(ALU_ADD), 32'h8,        2'b00};
        tbl[1]  = '{32'hFFFFFFFF, 32'h1,        4'(ALU_ADD), 32'h0,        2'b11};
        tbl[2]  = '{32'h3,        32'h5,        4'(ALU_SUB), 32'hFFFFFFFE, 2'b10};
        tbl[3]  = '{32'h7,        32'h7,        4'(ALU_SUB), 32'h0,        2'b01};
        tbl[4]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'(ALU_AND), 32'h00F000F0, 2'b00};
        tbl[5]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'(ALU_OR),  32'hFFF0FFF0, 2'b00};
        tbl[6]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'(ALU_XOR), 32'hFF00FF00, 2'b00};
        tbl[7]  = '{32'hFFFFFFFF, 32'h1,        4'(ALU_SLT), 32'h1,        2'b00};
        tbl[8]  = '{32'h1,        32'h4,        4'(ALU_SLL), 32'h10,       2'b00};
        tbl[9]  = '{32'h80000000, 32'h4,        4'(ALU_SRA), 32'hF8000000, 2'b00};
        tbl[10] = '{32'h1,        32'h2,        4'hF,        32'h0,        2'b01};

        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        chk("rst_issued",    32'(issued_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Single op: latency 2 into an empty FIFO.
        send(32'd5, 32'd3, 4'(ALU_ADD), 4'd7, 32'd8, 2'b00);
        chk("lat_cycle0_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(rsp_valid), 32'd0);
        chk("lat_cycle1_busy",  32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", 32'(rsp_valid), 32'd1);
        chk("single_data",      rsp_data, 32'd8);
        chk("single_tag",       32'(rsp_tag), 32'd7);
        chk("single_flags",     32'(rsp_flags), 32'd0);
        drain();

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ctrl, 4'(i), tbl[i].data, tbl[i].flags);
        end
        drain();
        chk("dir_issued", 32'(issued_cnt), 32'(acc));

        // Backpressure: only two ops fit while the consumer stalls.
        rsp_ready = 1'b0;
        send(32'd10, 32'd1, 4'(ALU_ADD), 4'd1, 32'd11, 2'b00);
        send(32'd10, 32'd2, 4'(ALU_SUB), 4'd2, 32'd8,  2'b00);
        req_a     = 32'd6;
        req_b     = 32'd1;
        req_ctrl  = 4'(ALU_SLL);
        req_tag   = 4'd3;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(req_ready), 32'd0);
        end
        chk("bp_issued", 32'(issued_cnt), 32'(acc));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(32'd6, 32'd1, 4'(ALU_SLL), 4'd3, 32'd12, 2'b00);
        send(32'd6, 32'd6, 4'(ALU_XOR), 4'd4, 32'd0,  2'b01);
        drain();

        // Asynchronous reset in the middle of a burst.
        rsp_ready = 1'b0;
        send(32'd9, 32'd4, 4'(ALU_ADD), 4'd5, 32'd13, 2'b00);
        send(32'd9, 32'd5, 4'(ALU_ADD), 4'd6, 32'd14, 2'b00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data",  rsp_data, 32'd0);
        chk("mid_rst_rsp_tag",   32'(rsp_tag), 32'd0);
        chk("mid_rst_busy",      32'(busy), 32'd0);
        chk("mid_rst_issued",    32'(issued_cnt), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        acc       = 0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rel_rsp_valid", 32'(rsp_valid), 32'd0);

        // Flush against a full FIFO with a request and a pop pending.
        rsp_ready = 1'b0;
        send(32'd1, 32'd1, 4'(ALU_ADD), 4'd9, 32'd2, 2'b00);
        send(32'd2, 32'd1, 4'(ALU_ADD), 4'd10, 32'd3, 2'b00);
        @(posedge clk);
        #1;
        chk("fl_full_valid", 32'(rsp_valid), 32'd1);
        req_a     = 32'd3;
        req_b     = 32'd3;
        req_ctrl  = 4'(ALU_ADD);
        req_tag   = 4'd11;
        req_valid = 1'b1;
        flush     = 1'b1;
        rsp_ready = 1'b1;
        sb.delete();
        acc = 0;
        @(negedge clk);
        chk("fl_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("fl_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("fl_busy",      32'(busy), 32'd0);
        chk("fl_issued",    32'(issued_cnt), 32'd0);
        chk("fl_issued_w",  32'(n_issued), 32'd0);
        chk("fl_hold_tag",  32'(rsp_tag), 32'd9);
        @(negedge clk);
        chk("fl_stay_empty", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Streaming: 100 ops, one accept per cycle.
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            send_rand(4'(i));
        end
        chk("stream_cycles", 32'(cyc - c0), 32'd100);
        drain();
        chk("stream_issued",   32'(issued_cnt), 32'd100);
        chk("stream_issued_w", 32'(n_issued), 32'd4);

        // Counter wrap on the 4-bit twin.
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        acc   = 0;
        for (int i = 0; i < 17; i++) begin
            send_rand(4'(i));
        end
        drain();
        chk("wrap_issued_w", 32'(n_issued), 32'd1);
        chk("wrap_issued",   32'(issued_cnt), 32'd17);

        // Pointer wrap with a toggling consumer.
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    send_rand(4'(i + 3));
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = k[0];
                end
            end
        join
        rsp_ready = 1'b1;
        drain();
        chk("ptr_issued", 32'(issued_cnt), 32'd26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
